// File: rtl/game_timer_ctrl_pkg.sv
// game_stats_pkg: state type, BCD time types and the BCD arithmetic helpers
// shared by the game countdown timer and its prescaler.
package game_stats_pkg;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } game_state_e;

   // One BCD digit, 0..9 when valid.
   typedef logic [3:0] bcd_digit_t;

   // Two-digit BCD time; the packed layout matches an 8'hTU literal.
   typedef struct packed {
      bcd_digit_t tens;
      bcd_digit_t units;
   } bcd_time_t;

   localparam bcd_time_t BCD_ZERO = 8'h00;
   localparam bcd_time_t BCD_MAX  = 8'h99;

   // Decrement by one second with a units borrow; 00 stays 00.
   function automatic bcd_time_t bcd_dec(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.units != 4'd0) begin
         r.units = t.units - 4'd1;
      end else if (t.tens != 4'd0) begin
         r.tens  = t.tens - 4'd1;
         r.units = 4'd9;
      end
      return r;
   endfunction

   // Digit-wise BCD add; any result above 99 clamps to 99.
   function automatic bcd_time_t bcd_add_sat(input bcd_time_t a, input bcd_time_t b);
      logic [4:0] u_sum;
      logic [4:0] t_sum;
      logic       carry;
      bcd_time_t  r;
      u_sum = {1'b0, a.units} + {1'b0, b.units};
      carry = (u_sum > 5'd9);
      if (carry) begin
         u_sum = u_sum - 5'd10;
      end
      t_sum = {1'b0, a.tens} + {1'b0, b.tens} + {4'd0, carry};
      if (t_sum > 5'd9) begin
         r = BCD_MAX;
      end else begin
         r.tens  = t_sum[3:0];
         r.units = u_sum[3:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/game_timer_ctrl_if.sv
// game_timer_ctrl_if: request strobes into the timer and the registered
// time/status coming back out.
interface game_timer_ctrl_if;
   import game_stats_pkg::*;

   logic       start;
   logic       pause;
   logic       resume;
   logic       bonus;
   bcd_digit_t tens;
   bcd_digit_t units;
   logic       running;
   logic       time_up;
   logic       expired;

   // Game logic side: issues requests, watches the clock.
   modport master (
      output start, pause, resume, bonus,
      input  tens, units, running, time_up, expired
   );

   // Timer side.
   modport slave (
      input  start, pause, resume, bonus,
      output tens, units, running, time_up, expired
   );
endinterface

// File: rtl/game_timer_ctrl_prescaler.sv
// sec_prescaler: divides clk down to one sec_tick per game second. It only
// advances while run is high, so a paused game keeps its partial second.
module sec_prescaler #(
   parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic sec_tick
);
   localparam int unsigned      CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICKS_PER_SEC - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // The tick is the last count of each second while running.
   assign sec_tick = run && (count_q == LAST);

   // Next count: clear beats everything, otherwise wrap at LAST while running.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (run) begin
         count_d = sec_tick ? '0 : count_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: two-digit BCD game countdown with pause/resume, bonus
// seconds and a one-cycle time_up pulse when the clock runs out.
module game_timer_ctrl
   import game_stats_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 50_000_000,
   parameter logic [7:0]  START_TIME    = 8'h60,
   parameter logic [7:0]  BONUS_SEC     = 8'h03
) (
   input logic              clk,
   input logic              reset,
   game_timer_ctrl_if.slave bus
);
   localparam bcd_time_t START_BCD = START_TIME;
   localparam bcd_time_t BONUS_BCD = BONUS_SEC;

   // Reject non-BCD load/bonus values at elaboration, one digit at a time.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bcd_check
      if (START_TIME[gi*4 +: 4] > 4'd9) begin : g_bad_start
         $error("game_timer_ctrl: START_TIME digit %0d is not BCD", gi);
      end
      if (BONUS_SEC[gi*4 +: 4] > 4'd9) begin : g_bad_bonus
         $error("game_timer_ctrl: BONUS_SEC digit %0d is not BCD", gi);
      end
   end
   if (TICKS_PER_SEC == 0) begin : g_bad_ticks
      $error("game_timer_ctrl: TICKS_PER_SEC must be at least 1");
   end

   game_state_e state_q;
   game_state_e state_d;
   bcd_time_t   time_q;
   bcd_time_t   time_d;
   logic        running_q;
   logic        running_d;
   logic        expired_q;
   logic        expired_d;
   logic        time_up_q;
   logic        time_up_d;

   logic        sec_tick;
   logic        presc_run;
   logic        presc_clear;
   bcd_time_t   tick_time;
   bcd_time_t   bonus_time;
   bcd_time_t   run_time;

   // The prescaler advances in RUN only and restarts on every accepted start.
   assign presc_run = (state_q == ST_RUN);

   sec_prescaler #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .run     (presc_run),
      .clear   (presc_clear),
      .sec_tick(sec_tick)
   );

   // sec_tick is only ever high in RUN, so in PAUSE tick_time is time_q and
   // bonus_time is simply time_q plus the bonus.
   assign tick_time  = sec_tick ? bcd_dec(time_q) : time_q;
   assign bonus_time = bcd_add_sat(tick_time, BONUS_BCD);

   // In RUN a bonus only counts when no pause is being accepted the same cycle
   // (pause outranks bonus); resume does nothing in RUN so it blocks nothing.
   assign run_time = (bus.bonus && !bus.pause) ? bonus_time : tick_time;

   // State and time update. start outranks everything; otherwise only the
   // highest-priority request that means something in the current state acts.
   always_comb begin
      state_d     = state_q;
      time_d      = time_q;
      time_up_d   = 1'b0;
      presc_clear = 1'b0;
      if (bus.start) begin
         state_d     = ST_RUN;
         time_d      = START_BCD;
         presc_clear = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               // A tick that still lands on a pause cycle is honoured, so the
               // partial second is never lost.
               time_d = run_time;
               if (sec_tick && (run_time == BCD_ZERO)) begin
                  state_d   = ST_EXPIRED;
                  time_up_d = 1'b1;
               end else if (bus.pause) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (bus.resume) begin
                  state_d = ST_RUN;
               end else if (bus.bonus) begin
                  time_d = bonus_time;
               end
            end
            ST_IDLE, ST_EXPIRED: begin
               state_d = state_q;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Status levels follow the state the block is entering.
   always_comb begin
      running_d = (state_d == ST_RUN);
      expired_d = (state_d == ST_EXPIRED);
   end

   // State, digit and status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         time_q    <= START_BCD;
         running_q <= 1'b0;
         expired_q <= 1'b0;
         time_up_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         time_q    <= time_d;
         running_q <= running_d;
         expired_q <= expired_d;
         time_up_q <= time_up_d;
      end
   end

   assign bus.tens    = time_q.tens;
   assign bus.units   = time_q.units;
   assign bus.running = running_q;
   assign bus.expired = expired_q;
   assign bus.time_up = time_up_q;
endmodule
